// File: rtl/instr_line_fill_pkg.sv
// Shared configuration for the instruction line-fill engine: line geometry,
// beat counter width and FSM state encoding.
package instr_line_fill_pkg;

    localparam int LINE_WORDS = 8;
    localparam int LINE_W     = LINE_WORDS * 32;
    localparam int OFFS_W     = $clog2(LINE_WORDS * 4);
    localparam int BEAT_W     = $clog2(LINE_WORDS);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DONE    = 3'd3,
        ST_RELEASE = 3'd4
    } fill_state_t;

endpackage

// File: rtl/instr_line_fill_buf.sv
// Line assembly register: one LINE_W-bit line written a word slot at a time.
// Slot 0 (lowest address) occupies the most significant word.
module line_assemble_buf
    import instr_line_fill_pkg::*;
(
    input  logic              CLK,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [BEAT_W-1:0] slot,
    input  logic [31:0]       wdata,
    output logic [LINE_W-1:0] line
);

    // Clear on request, otherwise overwrite only the addressed word slot
    always_ff @(posedge CLK) begin
        if (clear) begin
            line <= '0;
        end else begin
            for (int w = 0; w < LINE_WORDS; w++) begin
                if (wr_en && (slot == BEAT_W'(w))) begin
                    line[LINE_W-1-32*w -: 32] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/instr_line_fill.sv
// Memory-side fill engine for the L1 instruction cache. Fetches one line as
// LINE_WORDS single-word reads and returns it with a one-cycle line_valid.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | no fill in progress, waiting for req
// ISSUE   | read strobe for the current beat is on the memory port
// WAIT    | waiting for ram_rvalid; data lands in slot 'beat'
// DONE    | all beats stored; line_valid pulses and fill_count advances
// RELEASE | line delivered, holding off until L1 drops req
//
// Outputs are registered on the transition into a state so that ram_rd_en
// is high exactly while the FSM sits in ISSUE.
module instr_line_fill
    import instr_line_fill_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req,
    input  logic [31:0]       req_address,
    output logic [LINE_W-1:0] line_data,
    output logic              line_valid,
    output logic              busy,
    output logic              ram_rd_en,
    output logic [31:0]       ram_addr,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_rvalid,
    output logic [31:0]       fill_count
);

    fill_state_t           state;
    logic [BEAT_W-1:0]     beat;
    logic [BEAT_W-1:0]     beat_nxt;
    logic [31:OFFS_W]      base_tag;
    logic                  buf_wr;

    assign beat_nxt = beat + BEAT_W'(1);
    assign buf_wr   = (state == ST_WAIT) && ram_rvalid;

    line_assemble_buf u_buf (
        .CLK   (CLK),
        .clear (RESET),
        .wr_en (buf_wr),
        .slot  (beat),
        .wdata (ram_rdata),
        .line  (line_data)
    );

    // Fill sequencer: accept, issue/wait per beat, pulse, then hand-shake release
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            beat       <= '0;
            base_tag   <= '0;
            busy       <= 1'b0;
            ram_rd_en  <= 1'b0;
            ram_addr   <= '0;
            line_valid <= 1'b0;
            fill_count <= '0;
        end else begin
            ram_rd_en  <= 1'b0;
            line_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        base_tag  <= req_address[31:OFFS_W];
                        beat      <= '0;
                        busy      <= 1'b1;
                        ram_rd_en <= 1'b1;
                        ram_addr  <= {req_address[31:OFFS_W], {BEAT_W{1'b0}}, 2'b00};
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ram_rvalid) begin
                        if (beat == LAST_BEAT) begin
                            state <= ST_DONE;
                        end else begin
                            // beat only spans the offset field, so the tag never changes
                            beat      <= beat_nxt;
                            ram_rd_en <= 1'b1;
                            ram_addr  <= {base_tag, beat_nxt, 2'b00};
                            state     <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    line_valid <= 1'b1;
                    fill_count <= fill_count + 32'd1;
                    state      <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!req) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_line_fill.sv
// Self-checking bench for instr_line_fill with a latency-programmable memory
// model and scoreboard queues of expected read addresses and lines.
module tb_instr_line_fill;
    import instr_line_fill_pkg::*;

    logic              CLK;
    logic              RESET;
    logic              req;
    logic [31:0]       req_address;
    logic [LINE_W-1:0] line_data;
    logic              line_valid;
    logic              busy;
    logic              ram_rd_en;
    logic [31:0]       ram_addr;
    logic [31:0]       ram_rdata;
    logic              ram_rvalid;
    logic [31:0]       fill_count;

    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              spur_rvalid;
    int                mem_lat;
    int                ncyc;
    int                pend_due[$];
    logic [31:0]       pend_data[$];

    logic [31:0]       exp_addr_q[$];
    logic [LINE_W-1:0] exp_line_q[$];
    logic [LINE_W-1:0] last_line;
    logic [31:0]       exp_fills;
    int                vectors;
    int                miscompares;

    instr_line_fill dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .req         (req),
        .req_address (req_address),
        .line_data   (line_data),
        .line_valid  (line_valid),
        .busy        (busy),
        .ram_rd_en   (ram_rd_en),
        .ram_addr    (ram_addr),
        .ram_rdata   (ram_rdata),
        .ram_rvalid  (ram_rvalid),
        .fill_count  (fill_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign ram_rvalid = mem_rvalid | spur_rvalid;
    assign ram_rdata  = spur_rvalid ? 32'hDEAD_BEEF : mem_rdata;

    // Memory: word(A) = A, response mem_lat cycles after the strobe cycle
    always @(posedge CLK) begin
        if (RESET) begin
            pend_due.delete();
            pend_data.delete();
            mem_rvalid <= 1'b0;
        end else begin
            if (ram_rd_en) begin
                pend_due.push_back(ncyc - 1 + mem_lat);
                pend_data.push_back(ram_addr);
            end
            if (pend_due.size() > 0 && pend_due[0] == ncyc) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= pend_data.pop_front();
                void'(pend_due.pop_front());
            end else begin
                mem_rvalid <= 1'b0;
            end
        end
        ncyc = ncyc + 1;
    end

    // Called at a negedge; the following posedge is the accept edge (cycle 0)
    task automatic run_fill(input logic [31:0] addr, input int lat, input int exp_cyc,
                            input int hold, input bit move_addr, input bit spur_issue);
        logic [31:0]       base;
        logic [31:0]       ea;
        logic [LINE_W-1:0] el;
        int                k;
        int                rds;
        bit                done;
        base = {addr[31:OFFS_W], {OFFS_W{1'b0}}};
        el   = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            exp_addr_q.push_back(base + 32'(4 * i));
            el[LINE_W-1-32*i -: 32] = base + 32'(4 * i);
        end
        exp_line_q.push_back(el);
        req         = 1'b1;
        req_address = addr;
        mem_lat     = lat;
        k    = 0;
        rds  = 0;
        done = 1'b0;
        while (!done && k < 300) begin
            @(negedge CLK);
            if (move_addr && k == 5) req_address = 32'h0000_8000;
            if (spur_issue) spur_rvalid = (k == 0);
            if (ram_rd_en === 1'b1) begin
                vectors++;
                rds++;
                if (exp_addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_addr: extra read at %h, none expected", ram_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (ram_addr !== ea) begin
                        miscompares++;
                        $display("FAIL rd_addr: got %h expected %h", ram_addr, ea);
                    end
                end
            end
            if (line_valid === 1'b1) begin
                done = 1'b1;
                vectors++;
                if (k != exp_cyc) begin
                    miscompares++;
                    $display("FAIL latency: line_valid at cycle %0d expected %0d", k, exp_cyc);
                end
                el = exp_line_q.pop_front();
                vectors++;
                if (line_data !== el) begin
                    miscompares++;
                    $display("FAIL line_data: got %h expected %h", line_data, el);
                end
                exp_fills = exp_fills + 32'd1;
                vectors++;
                if (fill_count !== exp_fills) begin
                    miscompares++;
                    $display("FAIL fill_count: got %h expected %h", fill_count, exp_fills);
                end
            end
            k++;
        end
        spur_rvalid = 1'b0;
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: no line_valid for base %h", base);
            exp_line_q.delete();
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            vectors++;
            if (line_valid !== 1'b0 || ram_rd_en !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL hold: line_valid=%b rd_en=%b busy=%b expected 0 0 1",
                         line_valid, ram_rd_en, busy);
            end
        end
        req = 1'b0;
        @(negedge CLK);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_drop: got %b expected 0", busy);
        end
        vectors++;
        if (rds != LINE_WORDS || exp_addr_q.size() != 0) begin
            miscompares++;
            $display("FAIL rd_count: got %0d reads expected %0d", rds, LINE_WORDS);
        end
        exp_addr_q.delete();
        last_line = el;
    endtask

    task automatic test_reset;
        RESET       = 1'b1;
        spur_rvalid = 1'b1;
        repeat (3) @(negedge CLK);
        vectors++;
        if (busy !== 1'b0 || ram_rd_en !== 1'b0 || line_valid !== 1'b0 ||
            ram_addr !== 32'd0 || fill_count !== 32'd0 || line_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b rd_en=%b lv=%b addr=%h cnt=%h expected all 0",
                     busy, ram_rd_en, line_valid, ram_addr, fill_count);
        end
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        spur_rvalid = 1'b0;
        vectors++;
        if (line_data !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_rvalid: line_data=%h busy=%b expected 0", line_data, busy);
        end
    endtask

    task automatic test_basic;
        run_fill(32'h0000_1234, 1, 17, 0, 1'b0, 1'b0);
    endtask

    task automatic test_hold_req;
        run_fill(32'h0000_1234, 1, 17, 3, 1'b0, 1'b0);
    endtask

    task automatic test_latency_addr_change;
        run_fill(32'h0000_1234, 4, 41, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_fill;
        int rds;
        int pulses;
        req         = 1'b1;
        req_address = 32'h0000_0300;
        mem_lat     = 1;
        rds         = 0;
        for (int k = 0; k < 100 && rds < 4; k++) begin
            @(negedge CLK);
            if (ram_rd_en === 1'b1) rds++;
        end
        RESET = 1'b1;
        req   = 1'b0;
        @(negedge CLK);
        exp_fills = 32'd0;
        vectors++;
        if (busy !== 1'b0 || ram_rd_en !== 1'b0 || line_valid !== 1'b0 ||
            ram_addr !== 32'd0 || fill_count !== 32'd0 || line_data !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: busy=%b rd_en=%b lv=%b addr=%h cnt=%h expected all 0",
                     busy, ram_rd_en, line_valid, ram_addr, fill_count);
        end
        RESET  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (line_valid === 1'b1 || busy === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL abandoned_fill: %0d active cycles expected 0", pulses);
        end
        run_fill(32'h0000_0040, 1, 17, 0, 1'b0, 1'b0);
    endtask

    task automatic test_spurious;
        spur_rvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            vectors++;
            if (line_data !== last_line) begin
                miscompares++;
                $display("FAIL idle_rvalid: got %h expected %h", line_data, last_line);
            end
        end
        spur_rvalid = 1'b0;
        run_fill(32'h0000_2000, 1, 17, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_with_req;
        RESET       = 1'b1;
        req         = 1'b1;
        req_address = 32'h0000_5000;
        @(negedge CLK);
        vectors++;
        if (busy !== 1'b0 || ram_rd_en !== 1'b0 || line_data !== '0) begin
            miscompares++;
            $display("FAIL reset_wins: busy=%b rd_en=%b expected 0 0", busy, ram_rd_en);
        end
        RESET     = 1'b0;
        exp_fills = 32'd0;
        run_fill(32'h0000_5000, 1, 17, 0, 1'b0, 1'b0);
    endtask

    task automatic test_fill_count_wrap;
        @(negedge CLK);
        force dut.fill_count = 32'hFFFF_FFFF;
        @(negedge CLK);
        release dut.fill_count;
        @(negedge CLK);
        vectors++;
        if (fill_count !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL preload: got %h expected ffffffff", fill_count);
        end
        exp_fills = 32'hFFFF_FFFF;
        run_fill(32'h0000_7F60, 2, 25, 0, 1'b0, 1'b0);
    endtask

    initial begin
        RESET       = 1'b1;
        req         = 1'b0;
        req_address = 32'd0;
        spur_rvalid = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'd0;
        mem_lat     = 1;
        ncyc        = 0;
        exp_fills   = 32'd0;
        last_line   = '0;
        vectors     = 0;
        miscompares = 0;
        @(negedge CLK);
        test_reset();
        test_basic();
        test_hold_req();
        test_latency_addr_change();
        test_reset_mid_fill();
        test_spurious();
        test_reset_with_req();
        test_fill_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
